// File: rtl/muldiv_unit.sv
// RV64M iterative multiply/divide unit: shift-add multiply and restoring
// divide at one bit per cycle, with a registered register-file write port.
module muldiv_unit #(
   parameter int Width = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [4:0]       rd,
   input  logic [Width-1:0] rs1_val,
   input  logic [Width-1:0] rs2_val,
   output logic             busy,
   output logic             done,
   output logic [Width-1:0] result,
   output logic             RegWrite,
   output logic [4:0]       WriteDataTrig
);

   localparam int CW = $clog2(Width);
   localparam logic [Width-1:0] MinNeg = {1'b1, {(Width-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t state_q, state_n;

   logic [CW-1:0]      cnt_q;
   logic [2:0]         op_q;
   logic [4:0]         rd_q;
   logic [Width-1:0]   a_q, b_q;
   logic [Width-1:0]   quo_q, rem_q;
   logic [2*Width-1:0] prod_q;
   logic               neg_q;

   logic               sa, sb;
   logic [Width-1:0]   abs_a, abs_b;
   logic [Width-1:0]   a_n, b_n;
   logic               neg_n;

   assign sa    = rs1_val[Width-1];
   assign sb    = rs2_val[Width-1];
   assign abs_a = sa ? -rs1_val : rs1_val;
   assign abs_b = sb ? -rs2_val : rs2_val;

   // neg_n marks the final negation: product/quotient sign, or dividend sign for REM
   always_comb begin
      a_n   = rs1_val;
      b_n   = rs2_val;
      neg_n = 1'b0;
      unique case (op)
         3'b001: begin
            a_n   = abs_a;
            b_n   = abs_b;
            neg_n = sa ^ sb;
         end
         3'b010: begin
            a_n   = abs_a;
            neg_n = sa;
         end
         3'b100: begin
            a_n   = abs_a;
            b_n   = abs_b;
            neg_n = sa ^ sb;
         end
         3'b110: begin
            a_n   = abs_a;
            b_n   = abs_b;
            neg_n = sa;
         end
         default: ;
      endcase
   end

   logic             b_zero;
   logic             ovf;
   logic             special;
   logic [Width-1:0] spec_res;

   assign b_zero  = (rs2_val == '0);
   assign ovf     = !op[0] && (rs1_val == MinNeg) && (rs2_val == '1);
   assign special = op[2] && (b_zero || ovf);

   always_comb begin
      spec_res = '0;
      if (b_zero)
         spec_res = op[1] ? rs1_val : '1;
      else
         spec_res = op[1] ? '0 : rs1_val;
   end

   logic               last;
   logic [2*Width-1:0] addend;
   logic [2*Width-1:0] prod_n, prod_s;
   logic [Width:0]     rem_sh, diff;
   logic [Width-1:0]   rem_n, quo_n;
   logic [Width-1:0]   quo_s, rem_s;
   logic [Width-1:0]   fin_res;

   assign last   = (cnt_q == CW'(Width-1));
   assign addend = b_q[cnt_q] ? ({{Width{1'b0}}, a_q} << cnt_q) : '0;
   assign prod_n = prod_q + addend;

   // remainder stays below the divisor, so bit Width of diff is the borrow
   assign rem_sh = {rem_q, quo_q[Width-1]};
   assign diff   = rem_sh - {1'b0, b_q};
   assign rem_n  = diff[Width] ? rem_sh[Width-1:0] : diff[Width-1:0];
   assign quo_n  = {quo_q[Width-2:0], ~diff[Width]};

   assign prod_s = neg_q ? -prod_n : prod_n;
   assign quo_s  = neg_q ? -quo_n : quo_n;
   assign rem_s  = neg_q ? -rem_n : rem_n;

   always_comb begin
      fin_res = '0;
      unique case (1'b1)
         op_q == 3'b000:
            fin_res = prod_s[Width-1:0];
         !op_q[2] && (op_q != 3'b000):
            fin_res = prod_s[2*Width-1:Width];
         op_q[2] && !op_q[1]:
            fin_res = quo_s;
         op_q[2] && op_q[1]:
            fin_res = rem_s;
         default: ;
      endcase
   end

   always_comb begin
      state_n = state_q;
      unique case (state_q)
         IDLE: if (start) state_n = special ? DONE : CALC;
         CALC: if (last) state_n = DONE;
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   logic [4:0] rd_nx;
   assign rd_nx = (state_q == IDLE && start) ? rd : rd_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         RegWrite <= 1'b0;
      end else begin
         state_q  <= state_n;
         busy     <= (state_n != IDLE);
         done     <= (state_n == DONE);
         RegWrite <= (state_n == DONE) && (rd_nx != 5'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         op_q   <= '0;
         rd_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         prod_q <= '0;
         neg_q  <= 1'b0;
         result <= '0;
      end else begin
         unique case (state_q)
            IDLE: if (start) begin
               op_q   <= op;
               rd_q   <= rd;
               a_q    <= a_n;
               b_q    <= b_n;
               neg_q  <= neg_n;
               quo_q  <= a_n;
               rem_q  <= '0;
               prod_q <= '0;
               cnt_q  <= '0;
               if (special) result <= spec_res;
            end
            CALC: begin
               prod_q <= prod_n;
               rem_q  <= rem_n;
               quo_q  <= quo_n;
               cnt_q  <= last ? '0 : cnt_q + 1'b1;
               if (last) result <= fin_res;
            end
            default: ;
         endcase
      end
   end

   assign WriteDataTrig = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV64M cases plus randomized ops
// checked against a 128-bit arithmetic reference model.
module tb_muldiv_unit;

   localparam int W = 64;
   localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [2:0]   op;
   logic [4:0]   rd;
   logic [W-1:0] rs1_val, rs2_val;
   logic         busy, done, RegWrite;
   logic [W-1:0] result;
   logic [4:0]   WriteDataTrig;

   int checks = 0;
   int failures = 0;

   muldiv_unit #(.Width(W)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .op(op),
      .rd(rd),
      .rs1_val(rs1_val),
      .rs2_val(rs2_val),
      .busy(busy),
      .done(done),
      .result(result),
      .RegWrite(RegWrite),
      .WriteDataTrig(WriteDataTrig)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] model(
      input logic [2:0] f,
      input logic [W-1:0] a,
      input logic [W-1:0] b
   );
      logic [2*W-1:0] xa, xb, za, zb, p;
      logic signed [W-1:0] sa, sb, q;
      xa = {{W{a[W-1]}}, a};
      xb = {{W{b[W-1]}}, b};
      za = {{W{1'b0}}, a};
      zb = {{W{1'b0}}, b};
      sa = a;
      sb = b;
      p = '0;
      q = '0;
      case (f)
         3'd0: begin p = za * zb; q = p[W-1:0]; end
         3'd1: begin p = xa * xb; q = p[2*W-1:W]; end
         3'd2: begin p = xa * zb; q = p[2*W-1:W]; end
         3'd3: begin p = za * zb; q = p[2*W-1:W]; end
         3'd4: begin
            if (b == '0) q = '1;
            else if (a == MIN && b == '1) q = a;
            else q = sa / sb;
         end
         3'd5: q = (b == '0) ? '1 : a / b;
         3'd6: begin
            if (b == '0) q = a;
            else if (a == MIN && b == '1) q = '0;
            else q = sa % sb;
         end
         default: q = (b == '0) ? a : a % b;
      endcase
      return q;
   endfunction

   function automatic int exp_lat(
      input logic [2:0] f,
      input logic [W-1:0] a,
      input logic [W-1:0] b
   );
      if (f[2] && (b == '0 || (!f[0] && a == MIN && b == '1)))
         return 1;
      return W + 1;
   endfunction

   task automatic run_op(
      input  logic [2:0] f,
      input  logic [W-1:0] a,
      input  logic [W-1:0] b,
      input  logic [4:0] r,
      output int lat,
      output logic [W-1:0] res,
      output logic rw,
      output logic [4:0] wdt,
      output int ndone
   );
      @(negedge clk);
      start = 1'b1;
      op = f;
      rs1_val = a;
      rs2_val = b;
      rd = r;
      @(negedge clk);
      start = 1'b0;
      rs1_val = {$urandom, $urandom};
      rs2_val = {$urandom, $urandom};
      op = 3'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 31));
      lat = -1;
      res = '0;
      rw = 1'b0;
      wdt = '0;
      ndone = 0;
      for (int c = 1; c <= W + 10; c++) begin
         if (done) begin
            ndone++;
            if (lat < 0) begin
               lat = c;
               res = result;
               rw = RegWrite;
               wdt = WriteDataTrig;
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      op = 3'd0;
      rd = 5'd7;
      rs1_val = 64'd5;
      rs2_val = 64'd6;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, RegWrite} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=000",
                  {busy, done, RegWrite});
      end
      checks++;
      if (result !== '0 || WriteDataTrig !== 5'd0) begin
         failures++;
         $display("FAIL reset_data got=%h/%0d exp=0/0",
                  result, WriteDataTrig);
      end
      rst = 1'b0;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_start_dropped busy got=%b exp=0", busy);
      end
   endtask

   task automatic test_mul();
      int lat, nd;
      logic [W-1:0] res;
      logic rw;
      logic [4:0] wdt;
      run_op(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5,
             lat, res, rw, wdt, nd);
      checks++;
      if (lat !== 65) begin
         failures++;
         $display("FAIL mul_latency got=%0d exp=65", lat);
      end
      checks++;
      if (res !== 64'hFFFF_FFFF_FFFF_FFEB) begin
         failures++;
         $display("FAIL mul_result got=%h exp=ffffffffffffffeb", res);
      end
      checks++;
      if (rw !== 1'b1 || wdt !== 5'd5 || nd !== 1) begin
         failures++;
         $display("FAIL mul_write got=%b/%0d/%0d exp=1/5/1", rw, wdt, nd);
      end
   endtask

   task automatic test_mulh();
      int lat, nd;
      logic [W-1:0] res;
      logic rw;
      logic [4:0] wdt;
      logic [2:0] fs [3] = '{3'd3, 3'd1, 3'd2};
      logic [W-1:0] ex [3] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd0,
                               64'hFFFF_FFFF_FFFF_FFFF};
      for (int i = 0; i < 3; i++) begin
         run_op(fs[i], '1, '1, 5'd1, lat, res, rw, wdt, nd);
         checks++;
         if (res !== ex[i] || lat !== 65) begin
            failures++;
            $display("FAIL mulh_op%0d got=%h lat=%0d exp=%h lat=65",
                     fs[i], res, lat, ex[i]);
         end
      end
   endtask

   task automatic test_div();
      int lat, nd;
      logic [W-1:0] res;
      logic rw;
      logic [4:0] wdt;
      logic [2:0] fs [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
      logic [W-1:0] ex [4] = '{-64'sd3, -64'sd2,
                               64'h2AAA_AAAA_AAAA_AAA7, 64'd2};
      for (int i = 0; i < 4; i++) begin
         run_op(fs[i], -64'sd20, 64'd6, 5'd2, lat, res, rw, wdt, nd);
         checks++;
         if (res !== ex[i] || lat !== 65) begin
            failures++;
            $display("FAIL div_op%0d got=%h lat=%0d exp=%h lat=65",
                     fs[i], res, lat, ex[i]);
         end
      end
   endtask

   task automatic test_special();
      int lat, nd;
      logic [W-1:0] res;
      logic rw;
      logic [4:0] wdt;
      logic [2:0] fs [4] = '{3'd4, 3'd6, 3'd4, 3'd6};
      logic [W-1:0] as [4] = '{64'd9, 64'd9, MIN, MIN};
      logic [W-1:0] bs [4] = '{64'd0, 64'd0, '1, '1};
      logic [W-1:0] ex [4] = '{'1, 64'd9, MIN, 64'd0};
      for (int i = 0; i < 4; i++) begin
         run_op(fs[i], as[i], bs[i], 5'd3, lat, res, rw, wdt, nd);
         checks++;
         if (res !== ex[i] || lat !== 1 || nd !== 1) begin
            failures++;
            $display("FAIL special%0d got=%h lat=%0d n=%0d exp=%h lat=1 n=1",
                     i, res, lat, nd, ex[i]);
         end
      end
   endtask

   task automatic test_busy_ignore();
      int nd = 0;
      logic [W-1:0] res = '0;
      @(negedge clk);
      start = 1'b1;
      op = 3'd0;
      rs1_val = 64'd11;
      rs2_val = 64'd13;
      rd = 5'd3;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 2 * W + 20; c++) begin
         if (c == 10) begin
            start = 1'b1;
            op = 3'd5;
            rs1_val = 64'd100;
            rs2_val = 64'd0;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            nd++;
            res = result;
         end
         @(negedge clk);
      end
      start = 1'b0;
      checks++;
      if (nd !== 1 || res !== 64'd143) begin
         failures++;
         $display("FAIL busy_ignore got=n%0d/%h exp=n1/%h", nd, res,
                  64'd143);
      end
   endtask

   task automatic test_rd_zero();
      int lat, nd;
      logic [W-1:0] res;
      logic rw;
      logic [4:0] wdt;
      run_op(3'd0, 64'd6, 64'd7, 5'd0, lat, res, rw, wdt, nd);
      checks++;
      if (nd !== 1 || rw !== 1'b0 || res !== 64'd42) begin
         failures++;
         $display("FAIL rd_zero got=n%0d rw=%b res=%h exp=n1 rw=0 res=2a",
                  nd, rw, res);
      end
   endtask

   task automatic test_reset_midop();
      int lat, nd;
      int pulses = 0;
      logic [W-1:0] res;
      logic rw;
      logic [4:0] wdt;
      @(negedge clk);
      start = 1'b1;
      op = 3'd4;
      rs1_val = -64'sd1000;
      rs2_val = 64'd7;
      rd = 5'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
         failures++;
         $display("FAIL midop_reset got=busy%b done%b res=%h exp=0/0/0",
                  busy, done, result);
      end
      for (int c = 0; c < W + 10; c++) begin
         if (done || RegWrite) pulses++;
         @(negedge clk);
      end
      checks++;
      if (pulses !== 0) begin
         failures++;
         $display("FAIL midop_no_write got=%0d exp=0", pulses);
      end
      run_op(3'd0, 64'd3, 64'd4, 5'd1, lat, res, rw, wdt, nd);
      checks++;
      if (res !== 64'd12 || lat !== 65 || rw !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_mul got=%h lat=%0d rw=%b exp=c lat=65 rw=1",
                  res, lat, rw);
      end
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return '1;
         2: return MIN;
         3: return W'($urandom_range(0, 20));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic test_random();
      int lat, nd, el;
      logic [W-1:0] res, a, b, ex;
      logic rw;
      logic [4:0] wdt, r;
      logic [2:0] f;
      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom_range(0, 7));
         a = pick();
         b = pick();
         r = 5'($urandom_range(0, 31));
         ex = model(f, a, b);
         el = exp_lat(f, a, b);
         run_op(f, a, b, r, lat, res, rw, wdt, nd);
         checks++;
         if (res !== ex || lat !== el || nd !== 1) begin
            failures++;
            $display("FAIL rand%0d op%0d a=%h b=%h got=%h lat=%0d n=%0d exp=%h lat=%0d n=1",
                     i, f, a, b, res, lat, nd, ex, el);
         end
         checks++;
         if (rw !== (r != 5'd0) || wdt !== r) begin
            failures++;
            $display("FAIL rand%0d_write got=%b/%0d exp=%b/%0d",
                     i, rw, wdt, (r != 5'd0), r);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mulh();
      test_div();
      test_special();
      test_busy_ignore();
      test_rd_zero();
      test_reset_midop();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
